timer_1ms: RTL and testbench
============================

// Module: timer_1ms
//
// PURPOSE
//   Millisecond elapsed-time counter for the timed two-player sequence-matching game.
//   While Start is held high, a clock prescaler generates one tick per millisecond,
//   and T counts the elapsed milliseconds.
//   Dropping Start clears the measurement, so each player turn starts timing from zero.
//   Sits between the game FSM (drives Start) and the timeout/score comparison logic (reads T).
//
// PARAMETERS
//   CYCLES_PER_MS  50000  clock cycles per millisecond (50 MHz Clk); must be >= 1
//   T_WIDTH        21     width of the millisecond count T
//
// PORTS
//   Clk    in   1        system clock, all logic on rising edge
//   Rst    in   1        synchronous reset, active-low
//   Start  in   1        1 = run/accumulate, 0 = clear and hold at zero
//   T      out  T_WIDTH  elapsed milliseconds since Start last rose (registered)
//
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low. Rst is sampled only on the rising edge of Clk.
//   - Reset: on a rising edge with Rst=0, prescaler <= 0 and T <= 0. Rst has priority over Start.
//   - Prescaler: internal counter, width $clog2(CYCLES_PER_MS) (min 1 bit), range 0..CYCLES_PER_MS-1.
//   - Start=0 (Rst=1): prescaler <= 0 and T <= 0 on each edge. Clearing is synchronous, 1-cycle latency.
//   - Start=1 (Rst=1), prescaler != CYCLES_PER_MS-1: prescaler <= prescaler+1; T holds.
//   - Start=1 (Rst=1), prescaler == CYCLES_PER_MS-1: prescaler <= 0; T <= T+1 (see CONFIGURATION).
//   - First T increment is visible after the CYCLES_PER_MS-th consecutive edge sampling Start=1.
//     Thereafter T increments every CYCLES_PER_MS edges.
//   - CYCLES_PER_MS=1: T increments on every edge with Start=1.
//   - A single-cycle Start=0 glitch mid-count fully restarts the measurement (T and prescaler to 0).
//   - Reset mid-count clears everything. With Start held high through reset release,
//     counting resumes from 0 on the first edge after Rst returns high.
//   - No combinational path from inputs to T.
//
// CONFIGURATION
//   TIMER1MS_SATURATE_EN defined:
//     - T stops at 2^T_WIDTH-1 and holds there while Start=1.
//     - The prescaler keeps cycling.
//   TIMER1MS_SATURATE_EN undefined (default):
//     - T wraps from 2^T_WIDTH-1 to 0 on the next millisecond tick.
//
// TESTING  (bench uses CYCLES_PER_MS=4, 20 ns Clk)
//   1. Rst=0 for 1 edge, Start=0 -> T=0 after that edge; T stays 0 while Start=0.
//   2. Rst=1, Start=1 for 4 edges -> T=1 after edge 4.
//      Continue for 12 edges total -> T=3.
//   3. Start=1 for 3 edges, then Start=0 for 1 edge, then Start=1 for 3 edges
//      -> T=0 throughout (prescaler restarted).
//   4. Start=1 with T=5, assert Rst=0 for 1 edge -> T=0.
//      Release Rst, keep Start=1 -> T=1 after 4 more edges.
//   5. T_WIDTH=3, Start=1 for 32 edges -> T=0 at the 8th tick (wrap).
//      With TIMER1MS_SATURATE_EN defined -> T holds at 7.
//   6. CYCLES_PER_MS=1, Start=1 for 5 edges -> T=5; then Start=0 -> T=0 next edge.

Source files
------------

// File: rtl/timer_1ms.sv
// Millisecond elapsed-time counter for the two-player sequence-matching game.
// A prescaler divides Clk down to one tick per millisecond while Start is high;
// T counts those ticks. Dropping Start clears both counters synchronously.
// Optional feature macro: TIMER1MS_SATURATE_EN (T saturates instead of wrapping).

module timer_1ms #(
    parameter int unsigned CYCLES_PER_MS = 50000,
    parameter int unsigned T_WIDTH       = 21
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    output logic [T_WIDTH-1:0] T
);

    // A 1-cycle millisecond still needs a 1-bit prescaler; it simply stays at zero.
    localparam int unsigned PsWidth = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [PsWidth-1:0] PsLast = PsWidth'(CYCLES_PER_MS - 1);

    logic [PsWidth-1:0] ps_q, ps_d;
    logic [T_WIDTH-1:0] t_q, t_d;
    logic               tick;

    // Next-state logic: clear while idle, otherwise advance prescaler and count ticks.
    always_comb begin
        ps_d = ps_q;
        t_d  = t_q;
        tick = Start && (ps_q == PsLast);
        if (!Start) begin
            ps_d = '0;
            t_d  = '0;
        end else if (tick) begin
            ps_d = '0;
`ifdef TIMER1MS_SATURATE_EN
            // Hold at all-ones; the prescaler keeps cycling regardless.
            if (t_q != {T_WIDTH{1'b1}}) begin
                t_d = t_q + 1'b1;
            end
`else
            // Natural modulo-2^T_WIDTH wrap.
            t_d = t_q + 1'b1;
`endif
        end else begin
            ps_d = ps_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset taking priority over Start.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ps_q <= '0;
            t_q  <= '0;
        end else begin
            ps_q <= ps_d;
            t_q  <= t_d;
        end
    end

    assign T = t_q;

endmodule

// File: tb/tb_timer_1ms.sv
// Directed self-checking bench for timer_1ms.
// dut_a: CYCLES_PER_MS=4, T_WIDTH=21; dut_b: CYCLES_PER_MS=4, T_WIDTH=3 (wrap/saturate);
// dut_c: CYCLES_PER_MS=1, T_WIDTH=8. Expected values are hand-computed constants.

module tb_timer_1ms;

    logic        clk;
    logic        rst_a, rst_b, rst_c;
    logic        start_a, start_b, start_c;
    logic [20:0] t_a;
    logic [2:0]  t_b;
    logic [7:0]  t_c;

    int checks;
    int failures;

    timer_1ms #(.CYCLES_PER_MS(4), .T_WIDTH(21)) dut_a (
        .Clk(clk), .Rst(rst_a), .Start(start_a), .T(t_a)
    );
    timer_1ms #(.CYCLES_PER_MS(4), .T_WIDTH(3)) dut_b (
        .Clk(clk), .Rst(rst_b), .Start(start_b), .T(t_b)
    );
    timer_1ms #(.CYCLES_PER_MS(1), .T_WIDTH(8)) dut_c (
        .Clk(clk), .Rst(rst_c), .Start(start_c), .T(t_c)
    );

    // 20 ns clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge for sampling/driving.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;

        // 1. Reset, then idle with Start low.
        step(1);
        check_eq("reset_a", 32'(t_a), 0);
        check_eq("reset_b", 32'(t_b), 0);
        check_eq("reset_c", 32'(t_c), 0);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_eq("idle_zero", 32'(t_a), 0);
        end

        // 2. Run: first tick after 4th edge, T=3 after 12.
        start_a = 1'b1;
        step(3);
        check_eq("run_edge3", 32'(t_a), 0);
        step(1);
        check_eq("run_edge4", 32'(t_a), 1);
        step(4);
        check_eq("run_edge8", 32'(t_a), 2);
        step(3);
        check_eq("run_edge11", 32'(t_a), 2);
        step(1);
        check_eq("run_edge12", 32'(t_a), 3);

        // 3. Single-cycle Start glitch restarts the prescaler.
        start_a = 1'b0;
        step(1);
        check_eq("clear_1cyc", 32'(t_a), 0);
        start_a = 1'b1;
        step(3);
        check_eq("pre_glitch", 32'(t_a), 0);
        start_a = 1'b0;
        step(1);
        check_eq("glitch", 32'(t_a), 0);
        start_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_eq("post_glitch", 32'(t_a), 0);
        end
        step(1);
        check_eq("post_glitch_tick", 32'(t_a), 1);

        // 4. Reset mid-count with Start held high.
        start_a = 1'b0;
        step(1);
        start_a = 1'b1;
        step(20);
        check_eq("reach_5", 32'(t_a), 5);
        rst_a = 1'b0;
        step(1);
        check_eq("rst_mid", 32'(t_a), 0);
        rst_a = 1'b1;
        step(3);
        check_eq("rst_rel_3", 32'(t_a), 0);
        step(1);
        check_eq("rst_rel_4", 32'(t_a), 1);

        // 5. Narrow T: wrap (default) or saturate at 7.
        start_b = 1'b1;
        step(28);
        check_eq("narrow_7", 32'(t_b), 7);
        step(4);
`ifdef TIMER1MS_SATURATE_EN
        check_eq("narrow_tick8", 32'(t_b), 7);
        step(4);
        check_eq("narrow_tick9", 32'(t_b), 7);
`else
        check_eq("narrow_tick8", 32'(t_b), 0);
        step(4);
        check_eq("narrow_tick9", 32'(t_b), 1);
`endif

        // 6. One cycle per millisecond.
        start_c = 1'b1;
        step(1);
        check_eq("cpm1_edge1", 32'(t_c), 1);
        step(4);
        check_eq("cpm1_edge5", 32'(t_c), 5);
        start_c = 1'b0;
        step(1);
        check_eq("cpm1_clear", 32'(t_c), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
